// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
//   Shared definitions for the multiply/divide unit:
//     op_e        - 4-bit operation codes driven on md_unit.op
//     state_e     - md_unit control state (idle / multiply / divide)
//     div_phase_e - md_div_iter sequencing (idle / bit steps / sign fixup)
// ---------------------------------------------------------------------------
package md_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DV_IDLE = 2'd0,
    DV_RUN  = 2'd1,
    DV_FIX  = 2'd2
  } div_phase_e;

endpackage

// File: rtl/md_div_iter.sv
// ---------------------------------------------------------------------------
// md_div_iter
//   Iterative restoring divider. Operands are converted to magnitudes at
//   start, one quotient bit is produced per cycle for WIDTH cycles, then one
//   sign-fixup cycle presents the result with div_done high.
//   Ports:
//     clk, reset        - clock, asynchronous active-low reset
//     start             - load operands and begin (ignored unless idle)
//     abort             - drop the operation in flight, return to idle
//     signed_op         - 1: two's-complement operands, 0: unsigned
//     dividend, divisor - operands, sampled on start
//     div_done          - high for the single fixup cycle; results valid then
//     quotient          - divisor 0 gives all-ones
//     remainder         - divisor 0 gives the original dividend
// ---------------------------------------------------------------------------
module md_div_iter
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             div_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int STEP_W = $clog2(WIDTH + 1);

  div_phase_e       phase, phase_n;
  logic [STEP_W-1:0] step, step_n;
  logic [WIDTH-1:0] rem, rem_n;      // partial remainder (magnitude)
  logic [WIDTH-1:0] quo, quo_n;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs, dvs_n;      // divisor magnitude
  logic [WIDTH-1:0] dvd, dvd_n;      // original dividend, for the divide-by-0 result
  logic             neg_q, neg_q_n;
  logic             neg_r, neg_r_n;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    phase_n = phase;
    step_n  = step;
    rem_n   = rem;
    quo_n   = quo;
    dvs_n   = dvs;
    dvd_n   = dvd;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    dvd_neg = signed_op & dividend[WIDTH-1];
    dvs_neg = signed_op & divisor[WIDTH-1];
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};

    case (phase)
      DV_IDLE: begin
        if (start) begin
          phase_n = DV_RUN;
          step_n  = STEP_W'(WIDTH);
          rem_n   = '0;
          // The magnitude of the signed minimum is representable unsigned,
          // so min / -1 falls out of the normal path as quotient = min.
          quo_n   = dvd_neg ? -dividend : dividend;
          dvs_n   = dvs_neg ? -divisor : divisor;
          dvd_n   = dividend;
          neg_q_n = dvd_neg ^ dvs_neg;
          neg_r_n = dvd_neg;
        end
      end
      DV_RUN: begin
        // shifted < 2*dvs, so a successful subtract always fits in WIDTH bits.
        if (!diff[WIDTH]) begin
          rem_n = diff[WIDTH-1:0];
          quo_n = {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem_n = shifted[WIDTH-1:0];
          quo_n = {quo[WIDTH-2:0], 1'b0};
        end
        step_n = step - STEP_W'(1);
        if (step == STEP_W'(1)) phase_n = DV_FIX;
      end
      DV_FIX:  phase_n = DV_IDLE;
      default: phase_n = DV_IDLE;
    endcase

    if (abort) phase_n = DV_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= DV_IDLE;
      step  <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      dvd   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      phase <= phase_n;
      step  <= step_n;
      rem   <= rem_n;
      quo   <= quo_n;
      dvs   <= dvs_n;
      dvd   <= dvd_n;
      neg_q <= neg_q_n;
      neg_r <= neg_r_n;
    end
  end

  assign div_done  = (phase == DV_FIX);
  assign quotient  = (dvs == '0) ? '1  : (neg_q ? -quo : quo);
  assign remainder = (dvs == '0) ? dvd : (neg_r ? -rem : rem);

endmodule

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
//   Execute-stage multiply/divide unit owning the HI/LO registers.
//   Multiplies complete after MUL_LAT busy cycles, divides after WIDTH+1
//   (via md_div_iter). MTHI/MTLO write immediately. Every accepted start
//   snapshots {hi,lo} so a cancel from the Memory stage can roll back.
//   Optional macro MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU; when undefined
//   those codes behave as NOP and no accumulate adder is built.
//   Ports:
//     clk, reset  - clock, asynchronous active-low reset
//     start, op   - issue op (md_pkg::op_e) with operands d1 (rs), d2 (rt)
//     cancel      - roll back the most recent MD instruction
//     busy        - an operation is in flight
//     done        - one-cycle pulse after HI/LO commit from mult/div/acc
//     hi, lo      - architectural HI/LO
// ---------------------------------------------------------------------------
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);
  localparam int DW    = 2 * WIDTH;

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [DW-1:0]    pend, pend_n;      // result waiting for the MUL countdown
  logic [DW-1:0]    backup, backup_n;  // {hi,lo} at the most recent issue
  logic [WIDTH-1:0] hi_n, lo_n;
  logic             recent, recent_n;
  logic             done_n;
  logic             div_start, div_abort, div_done;
  logic [WIDTH-1:0] div_q, div_r;
  op_e              op_k;
  logic             mul_signed;
  logic [DW-1:0]    mul_a, mul_b, product;

  assign op_k = op_e'(op);
  assign busy = (state != ST_IDLE);

  // Sign- or zero-extending to 2*WIDTH makes the truncated product correct
  // for both signednesses.
  assign mul_signed = (op_k == OP_MULT) || (op_k == OP_MADD) || (op_k == OP_MSUB);
  assign mul_a      = mul_signed ? {{WIDTH{d1[WIDTH-1]}}, d1} : {{WIDTH{1'b0}}, d1};
  assign mul_b      = mul_signed ? {{WIDTH{d2[WIDTH-1]}}, d2} : {{WIDTH{1'b0}}, d2};
  assign product    = mul_a * mul_b;

`ifdef MD_MADD_EN
  logic [DW-1:0] acc;
  assign acc = ((op_k == OP_MSUB) || (op_k == OP_MSUBU)) ? ({hi, lo} - product)
                                                         : ({hi, lo} + product);
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pend_n    = pend;
    backup_n  = backup;
    hi_n      = hi;
    lo_n      = lo;
    recent_n  = 1'b0;
    done_n    = 1'b0;
    div_start = 1'b0;
    div_abort = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cancel) begin
          // Cancel beats a same-cycle start; only an MTHI/MTLO issued in the
          // previous cycle has anything to undo here.
          if (recent) {hi_n, lo_n} = backup;
        end else if (start) begin
          backup_n = {hi, lo};
          recent_n = 1'b1;
          case (op_k)
            OP_MULT, OP_MULTU: begin
              state_n = ST_MUL;
              cnt_n   = CNT_W'(MUL_LAT - 1);
              pend_n  = product;
            end
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              state_n = ST_MUL;
              cnt_n   = CNT_W'(MUL_LAT - 1);
              pend_n  = acc;
            end
`endif
            OP_DIV, OP_DIVU: begin
              state_n   = ST_DIV;
              div_start = 1'b1;
            end
            OP_MTHI: hi_n = d1;
            OP_MTLO: lo_n = d1;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (cancel) begin
          state_n = ST_IDLE;
        end else if (cnt == '0) begin
          {hi_n, lo_n} = pend;
          done_n       = 1'b1;
          state_n      = ST_IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (cancel) begin
          div_abort = 1'b1;
          state_n   = ST_IDLE;
        end else if (div_done) begin
          hi_n    = div_r;
          lo_n    = div_q;
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      pend   <= '0;
      backup <= '0;
      hi     <= '0;
      lo     <= '0;
      recent <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      pend   <= pend_n;
      backup <= backup_n;
      hi     <= hi_n;
      lo     <= lo_n;
      recent <= recent_n;
      done   <= done_n;
    end
  end

  md_div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .abort     (div_abort),
    .signed_op (op_k == OP_DIV),
    .dividend  (d1),
    .divisor   (d2),
    .div_done  (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit
//   Self-checking bench for md_unit (WIDTH=32, MUL_LAT=5). A reference model
//   built on 64-bit integer arithmetic tracks HI/LO and expected busy length.
//   Honours MD_MADD_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_md_unit;

  localparam int W   = 32;
  localparam int LAT = 5;

  localparam logic [3:0] C_NOP = 4'd0, C_MULT = 4'd1, C_MULTU = 4'd2, C_DIV = 4'd3,
                         C_DIVU = 4'd4, C_MTHI = 4'd5, C_MTLO = 4'd6, C_MADD = 4'd7,
                         C_MADDU = 4'd8, C_MSUB = 4'd9, C_MSUBU = 4'd10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] d1 = '0;
  logic [W-1:0] d2 = '0;
  logic         cancel = 1'b0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] ref_hi = '0;
  logic [W-1:0] ref_lo = '0;

  md_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .d1(d1), .d2(d2),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: updates ref_hi/ref_lo, returns expected busy cycles.
  task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int blen);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, acc;
    sa   = $signed(a);
    sb   = $signed(b);
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    acc  = {ref_hi, ref_lo};
    blen = 0;
    case (o)
      C_MULT:  begin acc = $unsigned(sa * sb); blen = LAT; end
      C_MULTU: begin acc = ua * ub;            blen = LAT; end
      C_DIV: begin
        blen = W + 1;
        if (b == 0) acc = {a, 32'hFFFF_FFFF};
        else begin q = sa / sb; r = sa % sb; acc = {r[31:0], q[31:0]}; end
      end
      C_DIVU: begin
        blen = W + 1;
        if (b == 0) acc = {a, 32'hFFFF_FFFF};
        else acc = {32'(ua % ub), 32'(ua / ub)};
      end
      C_MTHI: acc[63:32] = a;
      C_MTLO: acc[31:0]  = a;
`ifdef MD_MADD_EN
      C_MADD:  begin acc = acc + $unsigned(sa * sb); blen = LAT; end
      C_MADDU: begin acc = acc + ua * ub;            blen = LAT; end
      C_MSUB:  begin acc = acc - $unsigned(sa * sb); blen = LAT; end
      C_MSUBU: begin acc = acc - ua * ub;            blen = LAT; end
`endif
      default: ;
    endcase
    {ref_hi, ref_lo} = acc;
  endtask

  // Issue one op, measure busy length and done pulse, compare HI/LO.
  task automatic do_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string name);
    int   exp_busy, nbusy, ndone;
    logic exp_done;
    model(o, a, b, exp_busy);
    exp_done = (exp_busy > 0);
    @(negedge clk);
    start = 1'b1; op = o; d1 = a; d2 = b;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    ndone = 0;
    while (busy === 1'b1 && nbusy < 100) begin
      if (done !== 1'b0) ndone++;
      nbusy++;
      @(negedge clk);
    end
    checks++;
    if (nbusy != exp_busy) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, nbusy, exp_busy);
    end
    checks++;
    if (done !== exp_done || ndone != 0) begin
      errors++;
      $display("FAIL %s done: got %b (early pulses %0d) expected %b", name, done, ndone, exp_done);
    end
    checks++;
    if (hi !== ref_hi || lo !== ref_lo) begin
      errors++;
      $display("FAIL %s hilo: got %h_%h expected %h_%h", name, hi, lo, ref_hi, ref_lo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width: got %b expected 0", name, done);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_assert: got hi=%h lo=%h busy=%b done=%b expected all 0", hi, lo, busy, done);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got hi=%h lo=%h busy=%b done=%b expected all 0",
                 i, hi, lo, busy, done);
      end
    end
  endtask

  task automatic test_mult();
    do_op(C_MULT, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_neg2x3_const: got %h_%h expected ffffffff_fffffffa", hi, lo);
    end
    do_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    do_op(C_MULT,  32'h8000_0000, 32'h8000_0000, "mult_min_min");
  endtask

  task automatic test_div();
    do_op(C_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_neg7_2_const: got %h_%h expected ffffffff_fffffffd", hi, lo);
    end
    do_op(C_DIVU, 32'd5, 32'd0, "divu_by0");
    checks++;
    if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL divu_by0_const: got %h_%h expected 00000005_ffffffff", hi, lo);
    end
    do_op(C_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_min_neg1");
    do_op(C_DIV,  32'hFFFF_FFF7, 32'd0,         "div_neg_by0");
    do_op(C_DIV,  32'd7,         32'hFFFF_FFFE, "div_7_neg2");
    do_op(C_DIVU, 32'hFFFF_FFFF, 32'd1,         "divu_max_1");
  endtask

  task automatic test_mt_cancel();
    int blen;
    do_op(C_MTHI, 32'h0000_CAFE, 32'd0, "mthi_setup");
    do_op(C_MTLO, 32'h0000_BEEF, 32'd0, "mtlo_setup");
    @(negedge clk);
    start = 1'b1; op = C_MTHI; d1 = 32'h1234; d2 = '0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (hi !== 32'h1234 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi_visible: got hi=%h busy=%b expected hi=00001234 busy=0", hi, busy);
    end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (hi !== ref_hi || lo !== ref_lo || done !== 1'b0) begin
      errors++;
      $display("FAIL mthi_rollback: got %h_%h done=%b expected %h_%h done=0",
               hi, lo, done, ref_hi, ref_lo);
    end
    // A later cancel with nothing recent must leave the new value alone.
    model(C_MTLO, 32'h5A5A_0001, '0, blen);
    @(negedge clk);
    start = 1'b1; op = C_MTLO; d1 = 32'h5A5A_0001;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (hi !== ref_hi || lo !== ref_lo) begin
      errors++;
      $display("FAIL stale_cancel: got %h_%h expected %h_%h", hi, lo, ref_hi, ref_lo);
    end
  endtask

  task automatic cancel_busy(input logic [3:0] o, input int at_cycle, input string name);
    int ndone;
    @(negedge clk);
    start = 1'b1; op = o; d1 = 32'h0123_4567; d2 = 32'h89;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < at_cycle; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_before_cancel: got %b expected 1", name, busy);
    end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_cancel: got %b expected 0", name, busy);
    end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone != 0 || hi !== ref_hi || lo !== ref_lo) begin
      errors++;
      $display("FAIL %s no_commit: got done_pulses=%0d hilo=%h_%h expected 0 and %h_%h",
               name, ndone, hi, lo, ref_hi, ref_lo);
    end
  endtask

  task automatic test_cancel_start();
    int ndone;
    repeat (2) @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = C_MULT; d1 = 32'd77; d2 = 32'd99;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_start_busy: got %b expected 0", busy);
    end
    ndone = 0;
    repeat (8) begin
      if (done !== 1'b0) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone != 0 || hi !== ref_hi || lo !== ref_lo) begin
      errors++;
      $display("FAIL cancel_start_nochange: got done_pulses=%0d hilo=%h_%h expected 0 and %h_%h",
               ndone, hi, lo, ref_hi, ref_lo);
    end
  endtask

  task automatic test_madd();
    do_op(C_MULTU, 32'd2, 32'd3, "madd_setup");
    do_op(C_MADDU, 32'd4, 32'd5, "maddu_4x5");
    checks++;
`ifdef MD_MADD_EN
    if (hi !== 32'd0 || lo !== 32'd26) begin
      errors++;
      $display("FAIL maddu_const: got %h_%h expected 00000000_0000001a", hi, lo);
    end
`else
    if (hi !== 32'd0 || lo !== 32'd6) begin
      errors++;
      $display("FAIL maddu_nop_const: got %h_%h expected 00000000_00000006", hi, lo);
    end
`endif
    do_op(C_MSUB,  32'd10, 32'hFFFF_FFFF, "msub_neg");
    do_op(C_MSUBU, 32'hFFFF_FFFF, 32'd2,  "msubu_wrap");
    do_op(C_MADD,  32'h8000_0000, 32'd2,  "madd_min");
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic [3:0] o;
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 10));
      do_op(o, pick(), pick(), $sformatf("rand%0d_op%0d", i, o));
    end
  endtask

  task automatic test_reset_mid_div();
    do_op(C_MTHI, 32'h5555_0000, '0, "pre_reset_hi");
    do_op(C_MTLO, 32'h0000_6666, '0, "pre_reset_lo");
    @(negedge clk);
    start = 1'b1; op = C_DIV; d1 = 32'd100; d2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got hi=%h lo=%h busy=%b done=%b expected all 0", hi, lo, busy, done);
    end
    ref_hi = '0;
    ref_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got hi=%h lo=%h busy=%b done=%b expected all 0",
               hi, lo, busy, done);
    end
    do_op(C_MULT, 32'd1000, 32'hFFFF_FFF0, "mult_after_reset");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt_cancel();
    cancel_busy(C_MULTU, 3, "multu_cancel");
    cancel_busy(C_DIV, 12, "div_cancel");
    test_cancel_start();
    test_madd();
    test_random();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
